// File: rtl/tx_chain_dig.sv
// tx_chain_dig: splits each TX sample's LSB out as a delayed GPIO bit and zeroes it on the DAC path
module tx_chain_dig #(
  parameter int MAX_DELAY    = 15,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        strobe,
  input  logic [15:0] i_in,
  input  logic [15:0] q_in,
  input  logic [3:0]  delay,
  output logic [15:0] i_out_ana,
  output logic [15:0] q_out_ana,
  output logic        i_out_dig,
  output logic        q_out_dig,
  output logic        dig_valid
);
  localparam logic [1:0] DISABLED = 2'd0;
  localparam logic [1:0] FILLING  = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;
  localparam logic [1:0] IDLE     = 2'd3;
  localparam int FW = $clog2(MAX_DELAY + 2);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [1:0]             st;
  logic [MAX_DELAY:0][1:0] line;
  logic [MAX_DELAY:0][1:0] line_n;
  logic [FW-1:0]          fill;
  logic [FW-1:0]          fill_n;
  logic [IW-1:0]          idle_cnt;
  logic [1:0]             tap;
  logic                   hit;
  logic                   timed_out;
  // next delay-line contents and fill level if this clock pushes a sample; tap sees the new entry 0
  always_comb begin
    line_n    = {line[MAX_DELAY-1:0], i_in[0], q_in[0]};
    fill_n    = (fill == FW'(MAX_DELAY + 1)) ? fill : fill + FW'(1);
    tap       = line_n[delay];
    hit       = fill_n > FW'(delay);
    timed_out = idle_cnt == IW'(IDLE_TIMEOUT);
  end
  // analog path, delay line, digital outputs and mode sequencing; enable low parks everything digital
  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= DISABLED;
      line      <= '0;
      fill      <= '0;
      idle_cnt  <= '0;
      i_out_ana <= '0;
      q_out_ana <= '0;
      i_out_dig <= 1'b0;
      q_out_dig <= 1'b0;
      dig_valid <= 1'b0;
    end else begin
      if (strobe) begin
        i_out_ana <= enable ? {i_in[15:1], 1'b0} : i_in;
        q_out_ana <= enable ? {q_in[15:1], 1'b0} : q_in;
      end
      if (!enable) begin
        st        <= DISABLED;
        line      <= '0;
        fill      <= '0;
        idle_cnt  <= '0;
        i_out_dig <= 1'b0;
        q_out_dig <= 1'b0;
        dig_valid <= 1'b0;
      end else if (strobe) begin
        line                   <= line_n;
        fill                   <= fill_n;
        idle_cnt               <= '0;
        {i_out_dig, q_out_dig} <= tap;
        dig_valid              <= hit;
        st                     <= hit ? ACTIVE : FILLING;
      end else if (st == ACTIVE && timed_out) begin
        st        <= IDLE;
        i_out_dig <= 1'b0;
        q_out_dig <= 1'b0;
        dig_valid <= 1'b0;
      end else begin
        if (st == DISABLED) st <= FILLING;
        if ((st == FILLING || st == ACTIVE) && !timed_out) idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_tx_chain_dig.sv
// tb_tx_chain_dig: scoreboard bench for tx_chain_dig against a queue-based reference model
module tb_tx_chain_dig;
  localparam int MAXD = 15;
  localparam int T    = 8;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        strobe = 1'b0;
  logic [15:0] i_in = '0;
  logic [15:0] q_in = '0;
  logic [3:0]  delay = '0;
  logic [15:0] i_out_ana, q_out_ana;
  logic        i_out_dig, q_out_dig, dig_valid;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [34:0] sb[$];
  logic [1:0]  hist[$];
  int          quiet = 0;
  logic [15:0] ei = '0, eq = '0;
  logic        edi = 1'b0, edq = 1'b0, edv = 1'b0;

  tx_chain_dig #(.MAX_DELAY(MAXD), .IDLE_TIMEOUT(T)) dut (
    .clock(clk), .reset(reset), .enable(enable), .strobe(strobe),
    .i_in(i_in), .q_in(q_in), .delay(delay),
    .i_out_ana(i_out_ana), .q_out_ana(q_out_ana),
    .i_out_dig(i_out_dig), .q_out_dig(q_out_dig), .dig_valid(dig_valid)
  );

  always #5 clk = ~clk;

  // drive one clock of stimulus and push the model's expected post-edge outputs
  task automatic cyc(input bit r, input bit e, input bit s, input logic [15:0] i, input logic [15:0] q, input int d);
    @(negedge clk);
    reset = r; enable = e; strobe = s; i_in = i; q_in = q; delay = d[3:0];
    if (r) begin
      hist.delete(); quiet = 0;
      ei = '0; eq = '0; edi = 1'b0; edq = 1'b0; edv = 1'b0;
    end else if (!e) begin
      hist.delete(); quiet = 0;
      edi = 1'b0; edq = 1'b0; edv = 1'b0;
      if (s) begin ei = i; eq = q; end
    end else if (s) begin
      ei = {i[15:1], 1'b0};
      eq = {q[15:1], 1'b0};
      hist.push_front({i[0], q[0]});
      if (hist.size() > MAXD + 1) void'(hist.pop_back());
      {edi, edq} = (d < hist.size()) ? hist[d] : 2'b00;
      edv = hist.size() > d;
      quiet = 0;
    end else begin
      if (quiet <= T) quiet++;
      if (edv && quiet == T + 1) begin edi = 1'b0; edq = 1'b0; edv = 1'b0; end
    end
    sb.push_back({ei, eq, edi, edq, edv});
  endtask

  task automatic lit(input string n, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // monitor: every edge that follows issued stimulus presents one expected output word
  initial begin
    logic [34:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        w = sb.pop_front();
        n_tests++;
        if ({i_out_ana, q_out_ana, i_out_dig, q_out_dig, dig_valid} !== w) begin
          n_fail++;
          $display("FAIL sb @%0t: got ana=%h/%h dig=%b%b v=%b want ana=%h/%h dig=%b%b v=%b", $time,
                   i_out_ana, q_out_ana, i_out_dig, q_out_dig, dig_valid,
                   w[34:19], w[18:3], w[2], w[1], w[0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit want_dig[3] = '{1'b1, 1'b0, 1'b1};
    bit r, e, s;
    int d, gap;
    cyc(1, 0, 0, 16'h0, 16'h0, 0);
    cyc(1, 0, 1, 16'hffff, 16'hffff, 0);
    after_edge();
    lit("reset_state", {i_out_ana, q_out_ana}, 32'h0);
    lit("reset_dig", {29'd0, i_out_dig, q_out_dig, dig_valid}, 32'h0);
    cyc(0, 0, 1, 16'h1235, 16'h8001, 0);
    after_edge();
    lit("pass_ana", {i_out_ana, q_out_ana}, 32'h1235_8001);
    lit("pass_dig", {29'd0, i_out_dig, q_out_dig, dig_valid}, 32'h0);
    cyc(0, 1, 0, 16'h0, 16'h0, 0);
    cyc(0, 1, 1, 16'h1235, 16'h8000, 0);
    after_edge();
    lit("lsb_ana", {i_out_ana, q_out_ana}, 32'h1234_8000);
    lit("lsb_dig", {29'd0, i_out_dig, q_out_dig, dig_valid}, 32'h5);
    cyc(0, 0, 0, 16'h0, 16'h0, 3);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 1, {15'h0100, pat[k]}, 16'h2222, 3);
      after_edge();
      if (k == 2) lit("align_not_yet_valid", {31'd0, dig_valid}, 32'h0);
      if (k >= 3) lit($sformatf("align_dig_s%0d", k + 1), {30'd0, i_out_dig, dig_valid}, {30'd0, want_dig[k-3], 1'b1});
    end
    cyc(0, 1, 1, 16'h4321, 16'h0002, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 1, 0, 16'h0, 16'h0, 0);
      after_edge();
      if (k == T) lit("idle_still_valid", {30'd0, i_out_dig, dig_valid}, 32'h3);
      if (k == T + 1) begin
        lit("idle_dropped", {30'd0, i_out_dig, dig_valid}, 32'h0);
        lit("idle_ana_hold", {16'd0, i_out_ana}, 32'h4320);
      end
    end
    cyc(0, 1, 1, 16'h0007, 16'h0000, 0);
    after_edge();
    lit("idle_recover", {31'd0, dig_valid}, 32'h1);
    for (int k = 0; k < 20; k++) cyc(0, 1, 1, 16'($urandom), 16'($urandom), 2);
    cyc(0, 1, 1, 16'h1111, 16'h2222, 15);
    after_edge();
    lit("delay_change_valid", {31'd0, dig_valid}, 32'h1);
    cyc(0, 0, 1, 16'h0003, 16'h0003, 15);
    after_edge();
    lit("disable_dig", {29'd0, i_out_dig, q_out_dig, dig_valid}, 32'h0);
    cyc(0, 1, 1, 16'h0001, 16'h0001, 1);
    after_edge();
    lit("reenable_fill1", {31'd0, dig_valid}, 32'h0);
    cyc(0, 1, 1, 16'h0000, 16'h0001, 1);
    after_edge();
    lit("reenable_fill2", {31'd0, dig_valid}, 32'h1);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 16'($urandom), 16'($urandom), 1);
    cyc(1, 1, 1, 16'hffff, 16'hffff, 1);
    after_edge();
    lit("midreset_ana", {i_out_ana, q_out_ana}, 32'h0);
    lit("midreset_dig", {29'd0, i_out_dig, q_out_dig, dig_valid}, 32'h0);
    cyc(0, 1, 1, 16'h0001, 16'h0000, 1);
    after_edge();
    lit("postreset_s1", {31'd0, dig_valid}, 32'h0);
    cyc(0, 1, 1, 16'h0000, 16'h0000, 1);
    after_edge();
    lit("postreset_s2", {30'd0, i_out_dig, dig_valid}, 32'h3);
    d = 0;
    gap = 0;
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 299) == 0;
      e = $urandom_range(0, 79) != 0;
      if (gap == 0 && $urandom_range(0, 99) < 3) gap = $urandom_range(5, 14);
      if (gap > 0) begin s = 1'b0; gap--; end
      else s = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 63) == 0) d = $urandom_range(0, MAXD);
      cyc(r, e, s, 16'($urandom), 16'($urandom), d);
    end
    after_edge();
    after_edge();
    lit("scoreboard_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_chain_dig.md
# tx_chain_dig

Transmit-side companion to the RX digital-bit merge: pulls the LSB of each outgoing I/Q sample out as a digital GPIO bit and zeroes that LSB on the 16-bit path to the DAC. A programmable sample delay line lines the GPIO bits up with the DAC pipeline. An idle watchdog parks the GPIO bits at 0 when samples stop. It sits in the TX chain between the interpolator output and the DAC/GPIO output muxes.

## Interface
- MAX_DELAY, 15: deepest supported delay in samples; the delay line holds MAX_DELAY+1 entries.
- IDLE_TIMEOUT, 255: clocks without a strobe before the digital outputs go idle.

- clock  in  1  system clock; everything is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = extract the LSB and drive the digital bits; 0 = pass-through.
- strobe  in  1  one-clock pulse marking a valid sample on i_in/q_in.
- i_in  in  16  I sample from the interpolator.
- q_in  in  16  Q sample from the interpolator.
- delay  in  4  GPIO bit delay in samples, 0..MAX_DELAY.
- i_out_ana  out  16  registered I sample to the DAC.
- q_out_ana  out  16  registered Q sample to the DAC.
- i_out_dig  out  1  registered I digital bit to GPIO.
- q_out_dig  out  1  registered Q digital bit to GPIO.
- dig_valid  out  1  1 while the digital bits carry real, delayed sample data.

## Operation
- **Analog path.** On each strobe, i_out_ana <= enable ? {i_in[15:1],1'b0} : i_in; q_out_ana is formed the same way from q_in. The analog outputs hold between strobes and never idle.
- **Delay line.**
  - On each strobe with enable=1, {i_in[0],q_in[0]} is pushed into entry 0 and older entries shift up one place.
  - A fill counter increments on each push and saturates at MAX_DELAY+1.
- **Digital outputs.**
  - On each strobe with enable=1 and state FILLING or ACTIVE, {i_out_dig,q_out_dig} <= entry[delay], where entry[0] is the sample being pushed on this same strobe.
  - In every other state the digital outputs are 0.
- **State machine.** States are DISABLED, FILLING, ACTIVE and IDLE.
  - DISABLED: entered on reset, or from any state when enable=0. The delay line and fill counter are cleared, the digital outputs are 0 and dig_valid=0.
  - DISABLED -> FILLING when enable=1.
  - FILLING -> ACTIVE on the strobe that brings the fill count to delay+1. dig_valid=1 from that update on.
  - ACTIVE -> IDLE when the idle counter reaches IDLE_TIMEOUT. The digital outputs are forced to 0 and dig_valid=0 on the next clock.
  - IDLE -> ACTIVE on the next strobe. The delay line is preserved, and the outputs update from entry[delay] on that strobe.
- **Idle counter.** Cleared on every strobe; otherwise it increments, saturating at IDLE_TIMEOUT. It counts only in FILLING and ACTIVE.
- **Delay changes.**
  - `delay` is sampled only on strobe.
  - If the fill count is less than or equal to the new delay, the state returns to FILLING and dig_valid drops at that strobe.
  - Entries are never cleared by a delay change.
- **Simultaneous events.**
  - reset beats everything.
  - enable=0 with strobe: the analog output takes the pass-through value and the state goes to DISABLED.
  - A strobe on the same clock the idle counter hits IDLE_TIMEOUT: the strobe wins and the state stays ACTIVE.

## Timing
- Reset values: i_out_ana=0, q_out_ana=0, i_out_dig=0, q_out_dig=0, dig_valid=0, state DISABLED, all counters 0.
- Latency from a strobe at clock n:
  - Analog and digital outputs update at n+1; the two paths stay aligned to each other.
  - The digital bit shown at n+1 belongs to the sample strobed `delay` strobes earlier.
- dig_valid changes only on the same edges as the digital outputs, or on the idle, disable or reset edges.
- Back-to-back strobes (every clock) must be supported with no bubbles.
- Idle entry: the first clock with dig_valid=0 is IDLE_TIMEOUT+1 clocks after the last strobe's clock.
- Reset mid-operation: all outputs read reset values on the clock after reset is sampled high.

## Test plan
- **Pass-through.** enable=0, strobe with i_in=16'h1235, q_in=16'h8001 -> next clock i_out_ana=16'h1235, q_out_ana=16'h8001; both digital bits 0; dig_valid=0.
- **LSB extraction, delay=0.** enable=1, strobe with i_in=16'h1235, q_in=16'h8000 -> next clock i_out_ana=16'h1234, q_out_ana=16'h8000, i_out_dig=1, q_out_dig=0, dig_valid=1.
- **Delay alignment.** delay=3, strobes every clock with i_in LSB pattern 1,0,1,1,0,0:
  - dig_valid first rises after the 4th strobe.
  - i_out_dig on clocks after strobes 4,5,6 = 1,0,1.
- **Idle timeout.** IDLE_TIMEOUT=8, ACTIVE with i_out_dig=1, then strobes stop:
  - dig_valid=0 and i_out_dig=0 on the 9th clock after the last strobe; i_out_ana holds.
  - The next strobe restores dig_valid=1.
- **Delay change and disable.**
  - In ACTIVE with fill=16, delay 2->15 on a strobe -> stays ACTIVE and outputs entry[15].
  - enable dropped mid-stream -> DISABLED next clock, digital bits 0.
  - Re-enable -> FILLING, with fill restarting from 0.
- **Reset mid-stream.** reset pulsed while strobing every clock -> all outputs 0 next clock. The first strobe after reset with delay=1 gives dig_valid=0 until the 2nd strobe.
